regfile_dump_unit: RTL

- Read-side companion of the RISC-V core's register file.
- On command, it stalls the core and reads every architectural register through a dedicated read port.
- It streams each (index, value) pair out over a valid/ready interface, so end-of-run register contents are observable in hardware rather than through hierarchical peeking.
- It sits beside the core, between the register file's debug read port and a host/trace sink.

---
 rtl/regfile_dump_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_dump_unit.sv
// Register-file dump engine: stalls the core, walks every architectural register
// through the debug read port and streams (index, value) pairs over valid/ready.
module regfile_dump_unit #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              core_hold,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              addr_ok_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [ADDR_W-1:0] raddr_reg;
    logic              valid_reg;
    logic [ADDR_W-1:0] index_reg;
    logic [DATA_W-1:0] data_reg;

    // rf_raddr is registered, so the first word of a dump needs one extra ISSUE
    // cycle for the address to settle; later words get their address at handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            addr_ok_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            raddr_reg   <= '0;
            valid_reg   <= 1'b0;
            index_reg   <= '0;
            data_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= ISSUE;
                        idx_reg     <= '0;
                        addr_ok_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!addr_ok_reg) begin
                        raddr_reg   <= idx_reg;
                        addr_ok_reg <= 1'b1;
                    end else begin
                        data_reg  <= rf_rdata;
                        index_reg <= idx_reg;
                        valid_reg <= 1'b1;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        valid_reg <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            raddr_reg <= idx_reg + 1'b1;
                            state_reg <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign core_hold  = busy_reg;
    assign done       = done_reg;
    assign rf_raddr   = raddr_reg;
    assign dump_valid = valid_reg;
    assign dump_index = index_reg;
    assign dump_data  = data_reg;

endmodule
